// File: rtl/rv32i_types_pkg.sv
// Shared types and default sizing for the OOO decode/issue hazard unit.
// Enumerates functional-unit slots and the serialisation FSM states.
package rv32i_types_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int NUM_FU_DEF   = 4;
    localparam int NUM_WB_DEF   = 2;
    localparam int CB_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        ALU_FU = 2'd0,
        MUL_FU = 2'd1,
        DIV_FU = 2'd2,
        LS_FU  = 2'd3
    } fu_idx_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        WAIT    = 2'd2,
        REFETCH = 2'd3
    } serial_state_t;

endpackage

// File: rtl/ooo_scoreboard.sv
// Per-register busy/tag scoreboard: issue sets busy and records the writer's tag,
// writebacks clear only when their tag still owns the register, flush clears all busy bits.
module ooo_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int NUM_WB   = 2,
    parameter int REG_W    = 5,
    parameter int TAG_W    = 4
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      set_en,
    input  logic [REG_W-1:0]          set_rd,
    input  logic [TAG_W-1:0]          set_tag,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*REG_W-1:0]   wb_rd,
    input  logic [NUM_WB*TAG_W-1:0]   wb_tag,
    input  logic                      flush,
    output logic [NUM_REGS-1:0]       busy_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [TAG_W-1:0]    tag_q [NUM_REGS];
    logic [TAG_W-1:0]    tag_d [NUM_REGS];

    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        // A stale writeback (tag no longer owns rd) leaves the younger writer's busy bit set.
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p] &&
                tag_q[wb_rd[p*REG_W +: REG_W]] == wb_tag[p*TAG_W +: TAG_W]) begin
                busy_d[wb_rd[p*REG_W +: REG_W]] = 1'b0;
            end
        end
        if (set_en && set_rd != '0) begin
            busy_d[set_rd] = 1'b1;
            tag_d[set_rd]  = set_tag;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_q <= '0;
            tag_q  <= '{default: '0};
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/ooo_scoreboard_hazard_unit.sv
// Decode/issue hazard unit: RAW/WAW and structural checks against the scoreboard,
// serialisation FSM for CSR/fence/store, and stall/flush fan-out to the pipeline latches.
module ooo_scoreboard_hazard_unit
    import rv32i_types_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_FU   = NUM_FU_DEF,
    parameter int NUM_WB   = NUM_WB_DEF,
    parameter int CB_DEPTH = CB_DEPTH_DEF,
    localparam int REG_W   = $clog2(NUM_REGS),
    localparam int FU_W    = $clog2(NUM_FU),
    localparam int TAG_W   = $clog2(CB_DEPTH)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     dec_valid,
    input  logic [REG_W-1:0]         dec_rs1,
    input  logic [REG_W-1:0]         dec_rs2,
    input  logic [REG_W-1:0]         dec_rd,
    input  logic                     dec_rs1_used,
    input  logic                     dec_rs2_used,
    input  logic                     dec_wen,
    input  logic [FU_W-1:0]          dec_fu,
    input  logic                     dec_serial,
    input  logic [TAG_W-1:0]         dec_tag,
    input  logic [NUM_FU-1:0]        fu_busy,
    input  logic                     rob_full,
    input  logic                     rob_empty,
    input  logic                     i_mem_busy,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*REG_W-1:0]  wb_rd,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
    input  logic                     commit_valid,
    input  logic [TAG_W-1:0]         commit_tag,
    input  logic                     mispredict,
    input  logic                     insert_priv_pc,
    output logic                     issue,
    output logic                     data_hazard,
    output logic                     struct_hazard,
    output logic                     pc_en,
    output logic                     stall_fetch_decode,
    output logic                     fetch_decode_flush,
    output logic                     decode_execute_flush,
    output logic                     execute_commit_flush,
    output logic [NUM_REGS-1:0]      busy_vec,
    output serial_state_t            dbg_state
);

    serial_state_t    state_q, state_d;
    logic [TAG_W-1:0] serial_tag_q, serial_tag_d;
    logic             flush;
    logic             fu_hit;

    ooo_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WB   (NUM_WB),
        .REG_W    (REG_W),
        .TAG_W    (TAG_W)
    ) u_scoreboard (
        .CLK      (CLK),
        .nRST     (nRST),
        .set_en   (issue & dec_wen),
        .set_rd   (dec_rd),
        .set_tag  (dec_tag),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_tag   (wb_tag),
        .flush    (flush),
        .busy_o   (busy_vec)
    );

    assign flush = mispredict | insert_priv_pc;

    // An FU index with no unit behind it is treated as permanently busy.
    always_comb begin
        fu_hit = 1'b1;
        if (int'(dec_fu) < NUM_FU) begin
            fu_hit = fu_busy[dec_fu];
        end
    end

    assign data_hazard = dec_valid & ((dec_rs1_used & busy_vec[dec_rs1]) |
                                      (dec_rs2_used & busy_vec[dec_rs2]) |
                                      (dec_wen      & busy_vec[dec_rd]));
    assign struct_hazard = dec_valid & fu_hit;

    assign stall_fetch_decode = data_hazard | struct_hazard | rob_full |
                                (state_q != RUN) | (dec_serial & ~rob_empty);
    assign issue = dec_valid & ~stall_fetch_decode & ~flush;
    assign pc_en = ~(i_mem_busy | stall_fetch_decode);

    assign fetch_decode_flush   = flush | (state_q == REFETCH);
    assign decode_execute_flush = flush;
    assign execute_commit_flush = (state_q == REFETCH);
    assign dbg_state            = state_q;

    always_comb begin
        state_d      = state_q;
        serial_tag_d = serial_tag_q;
        case (state_q)
            RUN: begin
                if (dec_valid && dec_serial) begin
                    if (!rob_empty) begin
                        state_d = DRAIN;
                    end else if (issue) begin
                        state_d      = WAIT;
                        serial_tag_d = dec_tag;
                    end
                end
            end
            DRAIN:   if (rob_empty) state_d = RUN;
            WAIT:    if (commit_valid && commit_tag == serial_tag_q) state_d = REFETCH;
            REFETCH: state_d = RUN;
            default: state_d = RUN;
        endcase
        if (flush) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= RUN;
            serial_tag_q <= '0;
        end else begin
            state_q      <= state_d;
            serial_tag_q <= serial_tag_d;
        end
    end

endmodule

// File: tb/tb_ooo_scoreboard_hazard_unit.sv
// Directed bench for the hazard unit: scoreboard set/clear, hazards, serialisation FSM,
// flush override and asynchronous reset, checked with immediate assertions.
module tb_ooo_scoreboard_hazard_unit;
    import rv32i_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dec_valid, dec_rs1_used, dec_rs2_used, dec_wen, dec_serial;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [1:0]  dec_fu;
    logic [3:0]  dec_tag, commit_tag;
    logic [3:0]  fu_busy;
    logic        rob_full, rob_empty, i_mem_busy, commit_valid, mispredict, insert_priv_pc;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_rd;
    logic [7:0]  wb_tag;
    logic        issue, data_hazard, struct_hazard, pc_en, stall_fetch_decode;
    logic        fetch_decode_flush, decode_execute_flush, execute_commit_flush;
    logic [31:0] busy_vec;
    serial_state_t dbg_state;

    int tests  = 0;
    int failed = 0;

    ooo_scoreboard_hazard_unit dut (
        .CLK                  (CLK),
        .nRST                 (nRST),
        .dec_valid            (dec_valid),
        .dec_rs1              (dec_rs1),
        .dec_rs2              (dec_rs2),
        .dec_rd               (dec_rd),
        .dec_rs1_used         (dec_rs1_used),
        .dec_rs2_used         (dec_rs2_used),
        .dec_wen              (dec_wen),
        .dec_fu               (dec_fu),
        .dec_serial           (dec_serial),
        .dec_tag              (dec_tag),
        .fu_busy              (fu_busy),
        .rob_full             (rob_full),
        .rob_empty            (rob_empty),
        .i_mem_busy           (i_mem_busy),
        .wb_valid             (wb_valid),
        .wb_rd                (wb_rd),
        .wb_tag               (wb_tag),
        .commit_valid         (commit_valid),
        .commit_tag           (commit_tag),
        .mispredict           (mispredict),
        .insert_priv_pc       (insert_priv_pc),
        .issue                (issue),
        .data_hazard          (data_hazard),
        .struct_hazard        (struct_hazard),
        .pc_en                (pc_en),
        .stall_fetch_decode   (stall_fetch_decode),
        .fetch_decode_flush   (fetch_decode_flush),
        .decode_execute_flush (decode_execute_flush),
        .execute_commit_flush (execute_commit_flush),
        .busy_vec             (busy_vec),
        .dbg_state            (dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        dec_rs1_used = 0; dec_rs2_used = 0; dec_wen = 0; dec_fu = 0;
        dec_serial = 0; dec_tag = 0;
        fu_busy = 0; rob_full = 0; rob_empty = 1; i_mem_busy = 0;
        wb_valid = 0; wb_rd = 0; wb_tag = 0;
        commit_valid = 0; commit_tag = 0; mispredict = 0; insert_priv_pc = 0;
    endtask

    task automatic dec_write(input logic [4:0] rd, input logic [3:0] tag);
        dec_valid = 1; dec_wen = 1; dec_rd = rd; dec_tag = tag;
        dec_rs1_used = 0; dec_rs2_used = 0; dec_serial = 0; dec_fu = 0;
    endtask

    initial begin
        idle();
        nRST = 0;
        #2;
        chk("reset_busy", busy_vec, 32'h0);
        chk("reset_state", 32'(dbg_state), 32'(RUN));
        chk("reset_issue", 32'(issue), 0);
        chk("reset_flush", {29'd0, fetch_decode_flush, decode_execute_flush, execute_commit_flush}, 0);
        chk("reset_pc_en", 32'(pc_en), 1);
        tick();
        nRST = 1;
        tick();

        // RAW on x5 then cleared by matching writeback
        dec_write(5'd5, 4'd3); dec_rs1 = 5'd1; dec_rs1_used = 1;
        #1;
        chk("add_x5_issue", 32'(issue), 1);
        chk("add_x5_no_hazard", 32'(data_hazard), 0);
        tick();
        chk("x5_busy", busy_vec, 32'h20);
        dec_wen = 0; dec_rs1 = 5'd5; dec_rs1_used = 1;
        #1;
        chk("raw_x5_hazard", 32'(data_hazard), 1);
        chk("raw_x5_pc_en", 32'(pc_en), 0);
        chk("raw_x5_issue", 32'(issue), 0);
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd5}; wb_tag = {4'd0, 4'd3};
        tick();
        wb_valid = 0;
        #1;
        chk("wb_x5_cleared", busy_vec, 32'h0);
        chk("raw_x5_now_issues", 32'(issue), 1);
        tick();
        idle();

        // Stale-tag writeback must not clear a younger writer
        dec_write(5'd7, 4'd2);
        tick();
        chk("x7_tag2_busy", busy_vec, 32'h80);
        idle(); mispredict = 1;
        tick();
        mispredict = 0;
        chk("flush_clears_x7", busy_vec, 32'h0);
        dec_write(5'd7, 4'd4);
        tick();
        idle();
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd7}; wb_tag = {4'd0, 4'd2};
        tick();
        chk("stale_wb_keeps_x7", busy_vec, 32'h80);
        wb_valid = 2'b11; wb_rd = {5'd7, 5'd7}; wb_tag = {4'd4, 4'd3};
        tick();
        wb_valid = 0;
        chk("port1_match_clears_x7", busy_vec, 32'h0);
        // Same-cycle issue and writeback to x7: issue wins
        dec_write(5'd7, 4'd9);
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd7}; wb_tag = {4'd0, 4'd4};
        #1;
        chk("same_cycle_issue", 32'(issue), 1);
        tick();
        idle();
        chk("issue_beats_wb", busy_vec, 32'h80);
        wb_valid = 2'b10; wb_rd = {5'd7, 5'd0}; wb_tag = {4'd9, 4'd0};
        tick();
        idle();
        chk("wb_x7_tag9_clears", busy_vec, 32'h0);

        // Serialising CSR: drain, issue, wait commit, refetch
        dec_valid = 1; dec_serial = 1; dec_fu = 2'd3; dec_tag = 4'd6; rob_empty = 0;
        #1;
        chk("csr_stall_nonempty", 32'(stall_fetch_decode), 1);
        chk("csr_no_issue_nonempty", 32'(issue), 0);
        tick();
        chk("csr_drain", 32'(dbg_state), 32'(DRAIN));
        rob_empty = 1;
        #1;
        chk("drain_stall", 32'(stall_fetch_decode), 1);
        chk("drain_no_issue", 32'(issue), 0);
        tick();
        chk("drain_to_run", 32'(dbg_state), 32'(RUN));
        chk("csr_issue", 32'(issue), 1);
        tick();
        idle();
        chk("csr_wait", 32'(dbg_state), 32'(WAIT));
        chk("wait_stall", 32'(stall_fetch_decode), 1);
        commit_valid = 1; commit_tag = 4'd5;
        tick();
        chk("wrong_commit_stays_wait", 32'(dbg_state), 32'(WAIT));
        commit_tag = 4'd6;
        tick();
        commit_valid = 0;
        #1;
        chk("refetch_state", 32'(dbg_state), 32'(REFETCH));
        chk("refetch_fd_flush", 32'(fetch_decode_flush), 1);
        chk("refetch_ec_flush", 32'(execute_commit_flush), 1);
        chk("refetch_de_flush", 32'(decode_execute_flush), 0);
        tick();
        chk("refetch_to_run", 32'(dbg_state), 32'(RUN));
        chk("post_refetch_flush", {30'd0, fetch_decode_flush, execute_commit_flush}, 0);

        // Structural hazard on DIV
        dec_valid = 1; dec_fu = 2'd2; fu_busy = 4'b0100;
        #1;
        chk("div_struct_hazard", 32'(struct_hazard), 1);
        chk("div_struct_no_issue", 32'(issue), 0);
        fu_busy = 4'b0010;
        #1;
        chk("div_free_struct", 32'(struct_hazard), 0);
        chk("div_free_issue", 32'(issue), 1);
        tick();
        idle();

        // Build busy_vec = 0xF0 then mispredict
        for (int r = 4; r < 8; r++) begin
            dec_write(5'(r), 4'(r - 3));
            tick();
        end
        idle();
        chk("busy_f0", busy_vec, 32'hF0);
        dec_write(5'd8, 4'd7); mispredict = 1;
        #1;
        chk("mp_fd_flush", 32'(fetch_decode_flush), 1);
        chk("mp_de_flush", 32'(decode_execute_flush), 1);
        chk("mp_no_issue", 32'(issue), 0);
        tick();
        idle();
        chk("mp_busy_cleared", busy_vec, 32'h0);
        chk("mp_state_run", 32'(dbg_state), 32'(RUN));
        insert_priv_pc = 1;
        #1;
        chk("priv_de_flush", 32'(decode_execute_flush), 1);
        idle();

        // x0 never becomes busy
        dec_write(5'd0, 4'd1);
        #1;
        chk("x0_issue", 32'(issue), 1);
        tick();
        idle();
        chk("x0_not_busy", busy_vec, 32'h0);

        // Async reset while waiting on a serial commit
        dec_write(5'd9, 4'd1);
        tick();
        idle();
        dec_valid = 1; dec_serial = 1; dec_fu = 2'd3; dec_tag = 4'd6;
        tick();
        idle();
        chk("pre_reset_wait", 32'(dbg_state), 32'(WAIT));
        chk("pre_reset_busy", busy_vec, 32'h200);
        #1 nRST = 0;
        #1;
        chk("async_reset_state", 32'(dbg_state), 32'(RUN));
        chk("async_reset_busy", busy_vec, 32'h0);
        chk("async_reset_no_flush", {30'd0, fetch_decode_flush, execute_commit_flush}, 0);
        tick();
        nRST = 1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
